// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a scancode FIFO.
// Synchronises and deglitches the PS/2 pins, deframes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and queues accepted bytes.
// Optional build macro: PS2_KB_PREFIX_EN folds E0/F0 prefixes into the
// flags of the following entry (keyboard mode); undefined = mouse mode.
module ps2_rx_fifo #(
  parameter int unsigned DEGLITCH     = 8,
  parameter int unsigned TIMEOUT_BITS = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CW           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_rcv,
  input  logic          ps2clk_ext,
  input  logic          ps2data_ext,
  input  logic          rd_en,
  input  logic          clear_errors,
  output logic [7:0]    dout,
  output logic          dout_extended,
  output logic          dout_released,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          parity_err,
  output logic          frame_err,
  output logic          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                  state_q, state_d;
  logic                    clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic [2*DEGLITCH-1:0]   dg_q;
  logic [2:0]              bitcnt_q;
  logic [7:0]              shreg_q;
  logic                    par_q;
  logic [TIMEOUT_BITS-1:0] tmo_q;
  logic                    perr_q, ferr_q;

  logic edge_w, step_w, timeout_hit_w;
  logic shift_en, par_en, stop_chk, parity_bad, frame_bad;
  logic accept_w, perr_w, ferr_w;

  // 2-FF synchronisers and the deglitch history of the PS/2 clock
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q <= 1'b0;
      clk_sync_q <= 1'b0;
      dat_meta_q <= 1'b0;
      dat_sync_q <= 1'b0;
      dg_q       <= '0;
    end else begin
      clk_meta_q <= ps2clk_ext;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2data_ext;
      dat_sync_q <= dat_meta_q;
      dg_q       <= {dg_q[2*DEGLITCH-2:0], clk_sync_q};
    end
  end

  // Older half all high, newer half all low: a clean falling edge
  assign edge_w        = (dg_q[2*DEGLITCH-1:DEGLITCH] == '1) && (dg_q[DEGLITCH-1:0] == '0);
  assign step_w        = edge_w && enable_rcv;
  assign timeout_hit_w = (tmo_q == '1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable_rcv) begin
      state_d = S_IDLE;
    end else if (step_w) begin
      case (state_q)
        S_IDLE:   if (!dat_sync_q) state_d = S_DATA;
        S_DATA:   if (bitcnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end else if (timeout_hit_w) begin
      state_d = S_IDLE;
    end
  end

  // FSM outputs: datapath strobes and frame verdict
  always_comb begin
    shift_en   = step_w && (state_q == S_DATA);
    par_en     = step_w && (state_q == S_PARITY);
    stop_chk   = step_w && (state_q == S_STOP);
    parity_bad = ~(^shreg_q ^ par_q);
    frame_bad  = ~dat_sync_q;
    accept_w   = stop_chk && !parity_bad && !frame_bad;
    perr_w     = stop_chk && parity_bad;
    ferr_w     = stop_chk && !parity_bad && frame_bad;
  end

  // Bit deframing datapath, inactivity counter and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (step_w && state_q == S_IDLE) bitcnt_q <= '0;
      else if (shift_en)               bitcnt_q <= bitcnt_q + 3'd1;
      if (shift_en) shreg_q <= {dat_sync_q, shreg_q[7:1]};
      if (par_en)   par_q   <= dat_sync_q;
      if (step_w || state_q == S_IDLE || timeout_hit_w || !enable_rcv) tmo_q <= '0;
      else tmo_q <= tmo_q + TIMEOUT_BITS'(1);
      perr_q <= perr_w;
      ferr_q <= ferr_w;
    end
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

  logic       wr_req_w;
  logic [9:0] entry_w;

`ifdef PS2_KB_PREFIX_EN
  logic pend_ext_q, pend_rel_q;
  logic is_e0_w, is_f0_w, abort_w;

  assign is_e0_w  = (shreg_q == 8'hE0);
  assign is_f0_w  = (shreg_q == 8'hF0);
  assign wr_req_w = accept_w && !is_e0_w && !is_f0_w;
  assign abort_w  = perr_w || ferr_w || (timeout_hit_w && !step_w);
  assign entry_w  = {pend_rel_q, pend_ext_q, shreg_q};

  // Prefix flags wait for the next real scancode, dropped on any abort
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_ext_q <= 1'b0;
      pend_rel_q <= 1'b0;
    end else if (accept_w && is_e0_w) begin
      pend_ext_q <= 1'b1;
    end else if (accept_w && is_f0_w) begin
      pend_rel_q <= 1'b1;
    end else if (wr_req_w || abort_w) begin
      pend_ext_q <= 1'b0;
      pend_rel_q <= 1'b0;
    end
  end
`else
  assign wr_req_w = accept_w;
  assign entry_w  = {2'b00, shreg_q};
`endif

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          empty_w, full_w, pop_w, wr_do_w, ovf_set_w;
  logic [9:0]    head_w;

  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == CW'(FIFO_DEPTH));
  assign pop_w     = rd_en && !empty_w;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_do_w   = wr_req_w && (!full_w || pop_w);
  assign ovf_set_w = wr_req_w && full_w && !pop_w;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_do_w) mem_q[wr_ptr_q] <= entry_w;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_do_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_w)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_do_w && !pop_w)      count_q <= count_q + CW'(1);
      else if (pop_w && !wr_do_w) count_q <= count_q - CW'(1);
      if (ovf_set_w)         ovf_q <= 1'b1;
      else if (clear_errors) ovf_q <= 1'b0;
    end
  end

  assign head_w        = mem_q[rd_ptr_q];
  assign dout          = empty_w ? 8'h00 : head_w[7:0];
  assign dout_extended = !empty_w && head_w[8];
  assign dout_released = !empty_w && head_w[9];
  assign empty         = empty_w;
  assign full          = full_w;
  assign count         = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed testbench for ps2_rx_fifo (default parameters).
module tb_ps2_rx_fifo;

  localparam int HP = 16;

  logic       clk = 1'b0;
  logic       rst, enable_rcv, ps2clk_ext, ps2data_ext, rd_en, clear_errors;
  logic [7:0] dout;
  logic       dout_extended, dout_released, empty, full;
  logic [3:0] count;
  logic       parity_err, frame_err, overflow;

  int total = 0;
  int bad   = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;

  ps2_rx_fifo #(.DEGLITCH(8), .TIMEOUT_BITS(16), .FIFO_DEPTH(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .enable_rcv(enable_rcv),
    .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext),
    .rd_en(rd_en), .clear_errors(clear_errors),
    .dout(dout), .dout_extended(dout_extended), .dout_released(dout_released),
    .empty(empty), .full(full), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err) pe_cnt++;
    if (frame_err)  fe_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic send_bit(input logic b);
    ps2data_ext = b;
    repeat (HP) @(negedge clk);
    ps2clk_ext = 1'b0;
    repeat (HP) @(negedge clk);
    ps2clk_ext = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    ps2data_ext = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_rcv = 1'b1; ps2clk_ext = 1'b1; ps2data_ext = 1'b1;
    rd_en = 1'b0; clear_errors = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if ({dout_extended, dout_released} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {dout_extended, dout_released}); end
    total++; if ({parity_err, frame_err, overflow} !== 3'b000) begin bad++; $display("FAIL reset_errs got=%b exp=000", {parity_err, frame_err, overflow}); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int pe0, fe0;
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", empty); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    total++; if (dout !== 8'h1C) begin bad++; $display("FAIL single_dout got=%h exp=1c", dout); end
    total++; if ((pe_cnt - pe0) + (fe_cnt - fe0) !== 0) begin bad++; $display("FAIL single_noerr got=%0d exp=0", (pe_cnt - pe0) + (fe_cnt - fe0)); end
    pop();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
  endtask

  task automatic test_errors();
    int pe0, fe0;
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL parity_pulse got=%0d exp=1", pe_cnt - pe0); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL parity_empty got=%b exp=1", empty); end
    send_frame(8'h32, 1'b0, 1'b0);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL frame_pulse got=%0d exp=1", fe_cnt - fe0); end
    total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL frame_no_parity got=%0d exp=1", pe_cnt - pe0); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL frame_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_frame(b, odd_par(b), 1'b1);
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", full); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      total++; if (dout !== b) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, dout, b); end
      pop();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_drained got=%b exp=1", empty); end
    pop();
    total++; if ({empty, count} !== {1'b1, 4'd0}) begin bad++; $display("FAIL empty_pop got=%b/%0d exp=1/0", empty, count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pop_write();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'h41 + 8'(i);
      send_frame(b, odd_par(b), 1'b1);
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fpw_full got=%b exp=1", full); end
    b = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(odd_par(b));
    // stop bit; the accept strobe lands 10 negedges after the falling clock
    ps2data_ext = 1'b1;
    repeat (HP) @(negedge clk);
    ps2clk_ext = 1'b0;
    repeat (10) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fpw_count got=%0d exp=8", count); end
    repeat (HP - 11) @(negedge clk);
    ps2clk_ext = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpw_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 7; i++) begin
      b = 8'h42 + 8'(i);
      total++; if (dout !== b) begin bad++; $display("FAIL fpw_pop%0d got=%h exp=%h", i, dout, b); end
      pop();
    end
    total++; if (dout !== 8'h55) begin bad++; $display("FAIL fpw_last got=%h exp=55", dout); end
    pop();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpw_empty got=%b exp=1", empty); end
  endtask

  task automatic test_prefix();
    send_frame(8'hE0, odd_par(8'hE0), 1'b1);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    send_frame(8'h74, odd_par(8'h74), 1'b1);
`ifdef PS2_KB_PREFIX_EN
    total++; if (count !== 4'd1) begin bad++; $display("FAIL pfx_count got=%0d exp=1", count); end
    total++; if ({dout, dout_extended, dout_released} !== {8'h74, 2'b11}) begin bad++; $display("FAIL pfx_entry got=%h/%b%b exp=74/11", dout, dout_extended, dout_released); end
    pop();
`else
    total++; if (count !== 4'd3) begin bad++; $display("FAIL pfx_count got=%0d exp=3", count); end
    total++; if ({dout, dout_extended, dout_released} !== {8'hE0, 2'b00}) begin bad++; $display("FAIL pfx_e0 got=%h/%b%b exp=e0/00", dout, dout_extended, dout_released); end
    pop();
    total++; if ({dout, dout_extended, dout_released} !== {8'hF0, 2'b00}) begin bad++; $display("FAIL pfx_f0 got=%h/%b%b exp=f0/00", dout, dout_extended, dout_released); end
    pop();
    total++; if ({dout, dout_extended, dout_released} !== {8'h74, 2'b00}) begin bad++; $display("FAIL pfx_74 got=%h/%b%b exp=74/00", dout, dout_extended, dout_released); end
    pop();
`endif
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if ({dout, dout_extended, dout_released} !== {8'h1C, 2'b00}) begin bad++; $display("FAIL pfx_after got=%h/%b%b exp=1c/00", dout, dout_extended, dout_released); end
    pop();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL pfx_empty got=%b exp=1", empty); end
  endtask

  task automatic test_timeout();
    int pe0, fe0;
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2data_ext = 1'b1;
    repeat (65540) @(negedge clk);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    total++; if ({count, dout} !== {4'd1, 8'h5A}) begin bad++; $display("FAIL timeout_frame got=%0d/%h exp=1/5a", count, dout); end
    total++; if ((pe_cnt - pe0) + (fe_cnt - fe0) !== 0) begin bad++; $display("FAIL timeout_noerr got=%0d exp=0", (pe_cnt - pe0) + (fe_cnt - fe0)); end
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_en = 1'b0;
    ps2data_ext = 1'b1;
    total++; if ({empty, count} !== {1'b1, 4'd0}) begin bad++; $display("FAIL rstmid_empty got=%b/%0d exp=1/0", empty, count); end
    repeat (20) @(negedge clk);
    send_frame(8'h29, odd_par(8'h29), 1'b1);
    total++; if ({count, dout} !== {4'd1, 8'h29}) begin bad++; $display("FAIL rstmid_frame got=%0d/%h exp=1/29", count, dout); end
    pop();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_errors();
    test_overflow();
    test_full_pop_write();
    test_prefix();
    test_timeout();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
